// File: rtl/dm_responder_if.sv
// dm_responder_if: CPU data-memory request/response bundle.
interface dm_responder_if;
    logic [15:0] addr;
    logic [15:0] wrt_data;
    logic [15:0] rd_data;
    logic [15:0] acc_cnt;
    logic        re;
    logic        we;
    logic        rd_vld;
    logic        stall;
    modport master (output addr, re, we, wrt_data, input rd_data, rd_vld, stall, acc_cnt);
    modport slave  (input addr, re, we, wrt_data, output rd_data, rd_vld, stall, acc_cnt);
endinterface

// File: rtl/dm_responder.sv
// dm_responder: fixed-latency data memory that stalls the CPU until each access completes.
module dm_responder #(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 4
) (
    input logic           clk,
    input logic           rst,
    dm_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [15:0]         data_q, data_d;
    logic [15:0]         rd_data_q, rd_data_d;
    logic [15:0]         acc_cnt_q, acc_cnt_d;
    logic                wr_q, wr_d;
    logic                req, capture, fire;
    logic [15:0]         mem [2**ADDR_W];
    logic                unused_addr;
    assign unused_addr = ^bus.addr[15:ADDR_W];
    assign req     = bus.re | bus.we;
    assign capture = state_q == IDLE && req;
    assign fire    = state_q == WAIT && cnt_q == 4'd1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            wr_q      <= 1'b0;
            rd_data_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            wr_q      <= wr_d;
            rd_data_q <= rd_data_d;
            acc_cnt_q <= acc_cnt_d;
        end
    end
    // Array has no reset; a write only commits on the last WAIT cycle.
    always_ff @(posedge clk) begin
        if (fire && wr_q) mem[addr_q] <= data_q;
    end
    always_comb begin
        state_d = state_q == IDLE ? (req ? WAIT : IDLE) :
                  state_q == WAIT ? (cnt_q == 4'd1 ? DONE : WAIT) : IDLE;
    end
    always_comb begin
        cnt_d     = capture ? 4'(LATENCY) : state_q == WAIT ? cnt_q - 4'd1 : cnt_q;
        addr_d    = capture ? bus.addr[ADDR_W-1:0] : addr_q;
        data_d    = capture ? bus.wrt_data : data_q;
        wr_d      = capture ? bus.we : wr_q;
        rd_data_d = (fire && !wr_q) ? mem[addr_q] : rd_data_q;
        acc_cnt_d = fire ? acc_cnt_q + 16'd1 : acc_cnt_q;
    end
    always_comb begin
        bus.stall   = !rst && (state_q == WAIT || capture);
        bus.rd_vld  = state_q == DONE && !wr_q;
        bus.rd_data = rd_data_q;
        bus.acc_cnt = acc_cnt_q;
    end
endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: directed checks of dm_responder at LATENCY=4 and LATENCY=1.
module tb_dm_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    dm_responder_if b0();
    dm_responder_if b1();
    dm_responder #(.ADDR_W(8), .LATENCY(4)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
    dm_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic idle0();
        cyc();
        b0.re = 1'b0;
        b0.we = 1'b0;
        #1;
    endtask
    // Issues one request from IDLE and returns in the DONE cycle; inputs are scrambled during WAIT.
    task automatic access0(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        b0.re = r;
        b0.we = w;
        b0.addr = a;
        b0.wrt_data = d;
        #1;
        chk("issue_stall", 16'(b0.stall), 16'(r | w));
        for (int i = 0; i < 4; i++) begin
            cyc();
            b0.re = ~r;
            b0.we = ~w;
            b0.addr = a ^ 16'h00FF;
            b0.wrt_data = ~d;
            #1;
            chk("wait_stall", 16'(b0.stall), 16'd1);
        end
        cyc();
        chk("done_stall", 16'(b0.stall), 16'd0);
    endtask
    initial begin
        b0.re = 1'b0; b0.we = 1'b0; b0.addr = '0; b0.wrt_data = '0;
        b1.re = 1'b0; b1.we = 1'b0; b1.addr = '0; b1.wrt_data = '0;
        #12;
        rst = 1'b1;
        #1;
        chk("rst_rd_data", b0.rd_data, 16'h0000);
        chk("rst_rd_vld", 16'(b0.rd_vld), 16'd0);
        chk("rst_stall", 16'(b0.stall), 16'd0);
        chk("rst_acc_cnt", b0.acc_cnt, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        access0(1'b0, 1'b1, 16'h0012, 16'hBEEF);
        chk("wr_done_rd_vld", 16'(b0.rd_vld), 16'd0);
        chk("wr_done_acc", b0.acc_cnt, 16'd1);
        idle0();
        access0(1'b1, 1'b0, 16'h0012, 16'h0000);
        chk("rd_done_rd_vld", 16'(b0.rd_vld), 16'd1);
        chk("rd_done_data", b0.rd_data, 16'hBEEF);
        chk("rd_done_acc", b0.acc_cnt, 16'd2);
        idle0();
        chk("rd_vld_pulse", 16'(b0.rd_vld), 16'd0);
        chk("rd_data_hold", b0.rd_data, 16'hBEEF);
        access0(1'b0, 1'b1, 16'h0105, 16'h1234);
        idle0();
        access0(1'b1, 1'b0, 16'h0005, 16'h0000);
        chk("alias_data", b0.rd_data, 16'h1234);
        chk("alias_acc", b0.acc_cnt, 16'd4);
        idle0();
        access0(1'b1, 1'b1, 16'h0020, 16'h00AA);
        chk("both_rd_vld", 16'(b0.rd_vld), 16'd0);
        chk("both_rd_data", b0.rd_data, 16'h1234);
        idle0();
        access0(1'b1, 1'b0, 16'h0020, 16'h0000);
        chk("both_readback", b0.rd_data, 16'h00AA);
        chk("both_acc", b0.acc_cnt, 16'd6);
        idle0();
        access0(1'b0, 1'b1, 16'h0020, 16'h7777);
        chk("wr_keeps_rd_data", b0.rd_data, 16'h00AA);
        idle0();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("idle_stall", 16'(b0.stall), 16'd0);
            chk("idle_rd_vld", 16'(b0.rd_vld), 16'd0);
        end
        chk("idle_acc", b0.acc_cnt, 16'd7);
        access0(1'b0, 1'b1, 16'h0030, 16'h1111);
        chk("pre_wr_acc", b0.acc_cnt, 16'd8);
        idle0();
        b0.we = 1'b1;
        b0.addr = 16'h0030;
        b0.wrt_data = 16'h5555;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("midrst_stall", 16'(b0.stall), 16'd0);
        chk("midrst_acc", b0.acc_cnt, 16'd0);
        chk("midrst_rd_data", b0.rd_data, 16'h0000);
        chk("midrst_rd_vld", 16'(b0.rd_vld), 16'd0);
        b0.we = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_idle_stall", 16'(b0.stall), 16'd0);
        access0(1'b1, 1'b0, 16'h0030, 16'h0000);
        chk("dropped_wr_data", b0.rd_data, 16'h1111);
        chk("dropped_wr_acc", b0.acc_cnt, 16'd1);
        idle0();
        b1.we = 1'b1;
        b1.addr = 16'h0040;
        b1.wrt_data = 16'h0ABC;
        #1;
        chk("l1_issue_stall", 16'(b1.stall), 16'd1);
        cyc();
        chk("l1_wait_stall", 16'(b1.stall), 16'd1);
        cyc();
        chk("l1_done_stall", 16'(b1.stall), 16'd0);
        chk("l1_done_rd_vld", 16'(b1.rd_vld), 16'd0);
        chk("l1_acc", b1.acc_cnt, 16'd1);
        cyc();
        b1.we = 1'b0;
        force dut1.acc_cnt_d = 16'hFFFF;
        cyc();
        release dut1.acc_cnt_d;
        #1;
        chk("l1_preload", b1.acc_cnt, 16'hFFFF);
        b1.re = 1'b1;
        #1;
        chk("l1_rd_issue_stall", 16'(b1.stall), 16'd1);
        cyc();
        chk("l1_rd_wait_stall", 16'(b1.stall), 16'd1);
        cyc();
        chk("l1_rd_done_stall", 16'(b1.stall), 16'd0);
        chk("l1_rd_vld", 16'(b1.rd_vld), 16'd1);
        chk("l1_rd_data", b1.rd_data, 16'h0ABC);
        chk("l1_acc_wrap", b1.acc_cnt, 16'h0000);
        b1.re = 1'b0;
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
